// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/flush/halt controller:
// FSM state encoding and the hard-wired zero register index.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_e;

    localparam int REG0 = 0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: the instruction in ID reads a register that the
// load currently in EX has not yet produced. Writes to R0 never create a hazard.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rw,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_rw_nonzero;

    assign w_rw_nonzero = (ex_rw != REG_ADDR_W'(REG0));
    assign w_rs_match   = id_uses_rs && (id_rs == ex_rw);
    assign w_rt_match   = id_uses_rt && (id_rt == ex_rw);
    assign hazard       = ex_mem_read && w_rw_nonzero && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_control.sv
// Pipeline control: load-use stall, taken-branch flush, HALT drain/resume FSM.
// Optional perf counters are built only when PIPELINE_CONTROL_PERF_EN is defined.
module pipeline_control
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_branch_taken,
    input  logic                  id_halt,
    input  logic [REG_ADDR_W-1:0] ex_rw,
    input  logic                  ex_mem_read,
    input  logic                  resume,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    pipe_state_e        r_state;
    pipe_state_e        w_next_state;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [DRAIN_W-1:0] w_drain_next;
    logic               r_halted;
    logic               w_hazard;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_rw       (ex_rw),
        .ex_mem_read (ex_mem_read),
        .hazard      (w_hazard)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_drain_next;
            r_halted    <= (w_next_state == HALTED);
        end
    end

    // Stall beats branch beats halt; the HALT itself flows into ID/EX unbubbled.
    always_comb begin
        w_next_state = r_state;
        w_drain_next = r_drain_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        case (r_state)
            RUN: begin
                if (w_hazard) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (id_branch_taken) begin
                    if_id_flush = 1'b1;
                end else if (id_halt) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    w_drain_next = DRAIN_W'(DRAIN_CYCLES - 1);
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (r_drain_cnt == '0) begin
                    w_next_state = HALTED;
                end else begin
                    w_drain_next = r_drain_cnt - DRAIN_W'(1);
                end
            end
            HALTED: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (resume) begin
                    if_id_flush  = 1'b1;
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    assign halted = r_halted;

`ifdef PIPELINE_CONTROL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall;

    assign w_stall = (r_state == RUN) && w_hazard;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: vector table, directed multi-cycle sequences and
// random traffic against a cycle-level behavioural model.
module tb_pipeline_control;

    localparam int TB_ADDR_W  = 5;
    localparam int TB_CNT_W   = 8;
    localparam int TB_DRAIN   = 3;
    localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;
`ifdef PIPELINE_CONTROL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [TB_ADDR_W-1:0] id_rs, id_rt, ex_rw;
    logic                 id_uses_rs, id_uses_rt, id_branch_taken, id_halt;
    logic                 ex_mem_read, resume;
    logic                 pc_write, if_id_write, if_id_flush, id_ex_bubble, halted;
    logic [TB_CNT_W-1:0]  stall_cnt, flush_cnt;

    pipeline_control #(
        .REG_ADDR_W   (TB_ADDR_W),
        .CNT_W        (TB_CNT_W),
        .DRAIN_CYCLES (TB_DRAIN)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_branch_taken (id_branch_taken),
        .id_halt         (id_halt),
        .ex_rw           (ex_rw),
        .ex_mem_read     (ex_mem_read),
        .resume          (resume),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Behavioural model: pipeline is running, draining (cycles left) or halted.
    int m_stall, m_flush, m_drain_left;
    bit m_halted;

    function automatic bit hazard_m();
        if (!ex_mem_read || ex_rw == 0) return 1'b0;
        return (id_uses_rs && id_rs == ex_rw) || (id_uses_rt && id_rt == ex_rw);
    endfunction

    function automatic int exp_cnt(input int v);
        if (!PERF) return 0;
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_drain_left = 0; m_halted = 1'b0;
    endtask

    task automatic model_out(output bit e_pc, output bit e_ifw, output bit e_fl, output bit e_bub);
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
        if (m_halted) begin
            e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = resume;
        end else if (m_drain_left > 0) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end else if (hazard_m()) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end else if (id_branch_taken) begin
            e_fl = 1;
        end else if (id_halt) begin
            e_pc = 0; e_ifw = 0;
        end
    endtask

    task automatic model_update();
        if (m_halted) begin
            if (resume) begin m_halted = 1'b0; m_flush++; end
        end else if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
        end else if (hazard_m()) begin
            m_stall++;
        end else if (id_branch_taken) begin
            m_flush++;
        end else if (id_halt) begin
            m_drain_left = TB_DRAIN;
        end
    endtask

    task automatic check_cycle(input string tag);
        bit e_pc, e_ifw, e_fl, e_bub;
        model_out(e_pc, e_ifw, e_fl, e_bub);
        chk({tag, ".pc_write"},     32'(pc_write),     32'(e_pc));
        chk({tag, ".if_id_write"},  32'(if_id_write),  32'(e_ifw));
        chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e_fl));
        chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
        chk({tag, ".halted"},       32'(halted),       32'(m_halted));
        chk({tag, ".stall_cnt"},    32'(stall_cnt),    32'(exp_cnt(m_stall)));
        chk({tag, ".flush_cnt"},    32'(flush_cnt),    32'(exp_cnt(m_flush)));
    endtask

    task automatic set_idle();
        id_rs = '0; id_rt = '0; ex_rw = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_branch_taken = 0; id_halt = 0;
        ex_mem_read = 0; resume = 0;
    endtask

    task automatic drive_hazard();
        set_idle();
        ex_mem_read = 1; ex_rw = 5; id_rs = 5; id_uses_rs = 1;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        #1;
        check_cycle(tag);
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    typedef struct {
        logic [TB_ADDR_W-1:0] rs, rt, rw;
        logic urs, urt, br, mr;
        logic e_pc, e_ifw, e_fl, e_bub;
    } vec_t;

    function automatic vec_t mk(input int rs, input int urs, input int rt, input int urt,
                                input int rw, input int mr, input int br,
                                input int e_pc, input int e_ifw, input int e_fl, input int e_bub);
        vec_t v;
        v.rs = TB_ADDR_W'(rs); v.rt = TB_ADDR_W'(rt); v.rw = TB_ADDR_W'(rw);
        v.urs = 1'(urs); v.urt = 1'(urt); v.br = 1'(br); v.mr = 1'(mr);
        v.e_pc = 1'(e_pc); v.e_ifw = 1'(e_ifw); v.e_fl = 1'(e_fl); v.e_bub = 1'(e_bub);
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        //            rs urs rt urt rw mr br  pc ifw fl bub
        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);  // idle
        tbl[1] = mk(5, 1, 0, 0, 5, 1, 0,  0, 0, 0, 1);  // load-use on rs
        tbl[2] = mk(0, 0, 7, 1, 7, 1, 0,  0, 0, 0, 1);  // load-use on rt
        tbl[3] = mk(5, 0, 0, 0, 5, 1, 0,  1, 1, 0, 0);  // rs matches but unused
        tbl[4] = mk(0, 1, 0, 1, 0, 1, 0,  1, 1, 0, 0);  // R0 destination
        tbl[5] = mk(5, 1, 0, 0, 5, 0, 0,  1, 1, 0, 0);  // EX is not a load
        tbl[6] = mk(1, 1, 2, 1, 3, 1, 1,  1, 1, 1, 0);  // taken branch
        tbl[7] = mk(5, 1, 0, 0, 5, 1, 1,  0, 0, 0, 1);  // hazard wins over branch
        tbl[8] = mk(3, 1, 6, 1, 4, 1, 0,  1, 1, 0, 0);  // register mismatch

        set_idle();
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        #1;
        chk("reset.pc_write",    32'(pc_write),    32'd1);
        chk("reset.if_id_write", 32'(if_id_write), 32'd1);
        chk("reset.halted",      32'(halted),      32'd0);
        chk("reset.stall_cnt",   32'(stall_cnt),   32'd0);
        chk("reset.flush_cnt",   32'(flush_cnt),   32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            set_idle();
            id_rs = tbl[i].rs; id_uses_rs = tbl[i].urs;
            id_rt = tbl[i].rt; id_uses_rt = tbl[i].urt;
            ex_rw = tbl[i].rw; ex_mem_read = tbl[i].mr; id_branch_taken = tbl[i].br;
            #1;
            chk($sformatf("vec%0d.pc_write", i),     32'(pc_write),     32'(tbl[i].e_pc));
            chk($sformatf("vec%0d.if_id_write", i),  32'(if_id_write),  32'(tbl[i].e_ifw));
            chk($sformatf("vec%0d.if_id_flush", i),  32'(if_id_flush),  32'(tbl[i].e_fl));
            chk($sformatf("vec%0d.id_ex_bubble", i), 32'(id_ex_bubble), 32'(tbl[i].e_bub));
            step($sformatf("vec%0d", i));
        end

        // Single load-use stall counts once.
        do_reset();
        drive_hazard();
        step("loaduse");
        set_idle();
        step("loaduse_after");
        chk("loaduse.stall_cnt", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);

        // R0 never stalls.
        do_reset();
        ex_mem_read = 1; ex_rw = 0; id_rs = 0; id_uses_rs = 1;
        step("r0");
        set_idle();
        #1;
        chk("r0.stall_cnt", 32'(stall_cnt), 32'd0);

        // Branch flush, then branch plus hazard gives a bubble only.
        do_reset();
        id_branch_taken = 1;
        step("branch");
        drive_hazard();
        id_branch_taken = 1;
        #1;
        chk("branch_hz.if_id_flush", 32'(if_id_flush), 32'd0);
        step("branch_hz");
        set_idle();
        #1;
        chk("branch.flush_cnt", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
        chk("branch.stall_cnt", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);

        // HALT drains for three cycles; resume during drain is ignored.
        do_reset();
        id_halt = 1;
        #1;
        chk("halt.id_ex_bubble", 32'(id_ex_bubble), 32'd0);
        chk("halt.pc_write",     32'(pc_write),     32'd0);
        step("halt");
        for (int i = 0; i < TB_DRAIN; i++) begin
            set_idle();
            resume = (i == 1);
            #1;
            chk($sformatf("drain%0d.halted", i), 32'(halted), 32'd0);
            step($sformatf("drain%0d", i));
        end
        set_idle();
        #1;
        chk("halted.halted", 32'(halted), 32'd1);
        step("halted_idle");
        resume = 1;
        #1;
        chk("resume.if_id_flush", 32'(if_id_flush), 32'd1);
        step("resume");
        set_idle();
        #1;
        chk("resume.halted_after",   32'(halted),   32'd0);
        chk("resume.pc_write_after", 32'(pc_write), 32'd1);
        step("resume_after");

        // Asynchronous reset in the second DRAIN cycle.
        do_reset();
        drive_hazard();
        step("pre_halt_stall");
        set_idle();
        id_branch_taken = 1;
        step("pre_halt_flush");
        set_idle();
        id_halt = 1;
        step("rst_halt");
        set_idle();
        step("rst_drain0");
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_drain.pc_write",     32'(pc_write),     32'd1);
        chk("rst_drain.if_id_write",  32'(if_id_write),  32'd1);
        chk("rst_drain.id_ex_bubble", 32'(id_ex_bubble), 32'd0);
        chk("rst_drain.halted",       32'(halted),       32'd0);
        chk("rst_drain.stall_cnt",    32'(stall_cnt),    32'd0);
        chk("rst_drain.flush_cnt",    32'(flush_cnt),    32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        step("rst_drain_run");

        // Stall counter saturation.
        do_reset();
        drive_hazard();
        for (int i = 0; i < (1 << TB_CNT_W) + 2; i++) step("sat");
        set_idle();
        #1;
        chk("sat.stall_cnt", 32'(stall_cnt), PERF ? 32'(CNT_MAX) : 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_rw           = TB_ADDR_W'($urandom_range(0, 3));
            id_rs           = TB_ADDR_W'($urandom_range(0, 3));
            id_rt           = TB_ADDR_W'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_branch_taken = ($urandom_range(0, 3) == 0);
            id_halt         = ($urandom_range(0, 15) == 0) && !id_branch_taken;
            resume          = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
